// File: rtl/spi_write_master.sv
// -----------------------------------------------------------------------------
// spi_write_master
//
// Write-only SPI master, mode 0 (sclk idles low). Each accepted request sends
// one frame while cs_n is low:
//   8 command bits (CMD, LSB first),
//   DATA_BITS payload bits (MSB first),
//   1 trailing copy pulse with mosi = 0.
// A setup period precedes the first pulse, a tail period follows the last one,
// and a gap period with cs_n high separates frames.
//
// Parameters:
//   DATA_BITS  payload bits per transfer (>= 1)
//   CLK_DIV    clk cycles per sclk half-period (>= 1)
//   CMD        command byte sent before every payload
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   transfer request
//   in_data    payload, captured only when the request is accepted
//   in_ready   request can be accepted this cycle (combinational)
//   sclk       SPI clock (registered)
//   mosi       SPI serial data out (registered)
//   cs_n       SPI chip select, active low (registered)
//   busy       frame or post-frame gap in progress (registered)
//   done       one-cycle pulse as cs_n returns high (registered)
// -----------------------------------------------------------------------------
module spi_write_master #(
    parameter int         DATA_BITS = 16,
    parameter int         CLK_DIV   = 4,
    parameter logic [7:0] CMD       = 8'b1001_0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 cs_n,
    output logic                 busy,
    output logic                 done
);

    // Pulses per frame: command byte, payload, one copy pulse.
    localparam int N     = 8 + DATA_BITS + 1;
    localparam int CNT_W = $clog2(N + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CMD_BITS   = CNT_W'(8);
    localparam logic [CNT_W-1:0] PAY_END    = CNT_W'(8 + DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_PULSE = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        TAIL  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t               state;
    logic [DIV_W-1:0]     div_cnt;   // cycles spent in the current half-period
    logic [CNT_W-1:0]     bit_cnt;   // sclk pulses completed in this frame
    logic [DATA_BITS-1:0] shreg;     // payload, MSB is the next payload bit

    logic                 div_last;
    logic [CNT_W-1:0]     bit_nxt;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic                 next_bit;

    assign in_ready = (state == IDLE) && rst_n;

    // Bit to present on mosi after the falling edge that completes pulse
    // bit_cnt+1. The payload register only advances once a payload bit has
    // actually been sent, so the first payload bit is its unshifted MSB.
    always_comb begin
        // NOTE: every variable gets a default before any condition, so no
        // path through this block leaves one unassigned and infers a latch.
        div_last  = (div_cnt == DIV_LAST);
        bit_nxt   = bit_cnt + CNT_W'(1);
        shreg_nxt = (bit_cnt >= CMD_BITS) ? (shreg << 1) : shreg;
        next_bit  = 1'b0;
        if (bit_nxt < CMD_BITS) begin
            next_bit = CMD[bit_nxt[2:0]];
        end else if (bit_nxt < PAY_END) begin
            next_bit = shreg_nxt[DATA_BITS-1];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state and outputs use non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            state   <= IDLE;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk    <= 1'b0;
                    mosi    <= 1'b0;
                    cs_n    <= 1'b1;
                    busy    <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (in_valid && in_ready) begin
                        state <= SETUP;
                        shreg <= in_data;
                        cs_n  <= 1'b0;
                        busy  <= 1'b1;
                        mosi  <= CMD[0];
                    end
                end

                SETUP: begin
                    if (div_last) begin
                        state   <= SHIFT;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                // sclk alternates CLK_DIV cycles low / CLK_DIV cycles high.
                // mosi only moves together with the falling edge.
                SHIFT: begin
                    if (!div_last) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_nxt;
                            shreg   <= shreg_nxt;
                            mosi    <= next_bit;
                            if (bit_cnt == LAST_PULSE) begin
                                state <= TAIL;
                            end
                        end
                    end
                end

                TAIL: begin
                    sclk <= 1'b0;
                    mosi <= 1'b0;
                    if (div_last) begin
                        state   <= GAP;
                        cs_n    <= 1'b1;
                        done    <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                GAP: begin
                    if (div_last) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                // Unused encodings recover to IDLE with reset-value outputs.
                default: begin
                    state   <= IDLE;
                    sclk    <= 1'b0;
                    mosi    <= 1'b0;
                    cs_n    <= 1'b1;
                    busy    <= 1'b0;
                    shreg   <= '0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_write_master.sv
// -----------------------------------------------------------------------------
// tb_spi_write_master
//
// Self-checking bench for spi_write_master. Two instances:
//   dut0  defaults (DATA_BITS=16, CLK_DIV=4)
//   dut1  DATA_BITS=1, CLK_DIV=1
// Stimulus pushes the expected frame (mosi at each sclk rise, cs_n low time,
// gap before the frame, done at the end) into a queue; a monitor sampling on
// the falling clk edge rebuilds each frame from the pins and pops/compares
// when cs_n returns high.
// -----------------------------------------------------------------------------
module tb_spi_write_master;

    localparam logic [7:0] CMD_BYTE = 8'b1001_0001;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic [15:0] in_data  = '0;
    logic        in_ready, sclk, mosi, cs_n, busy, done;

    logic        in_valid2 = 1'b0;
    logic [0:0]  in_data2  = '0;
    logic        in_ready2, sclk2, mosi2, cs_n2, busy2, done2;

    always #5 clk = ~clk;

    spi_write_master dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .busy     (busy),
        .done     (done)
    );

    spi_write_master #(
        .DATA_BITS (1),
        .CLK_DIV   (1)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid2),
        .in_data  (in_data2),
        .in_ready (in_ready2),
        .sclk     (sclk2),
        .mosi     (mosi2),
        .cs_n     (cs_n2),
        .busy     (busy2),
        .done     (done2)
    );

    typedef struct {
        int          dut;
        logic [63:0] bits;     // mosi expected at rise i in bit i
        int          nrise;
        int          low;      // cs_n low cycles
        bit          aborted;
        int          gap;      // cs_n high cycles before this frame, -1 = skip
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int exp_done [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int dbits(input int d);
        return (d == 0) ? 16 : 1;
    endfunction

    function automatic int cdiv(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Expected frame; cut > 0 means the frame is aborted after cut rises.
    function automatic exp_t make_exp(input int d, input logic [15:0] data, input int cut);
        exp_t e;
        int   db;
        int   n;
        db        = dbits(d);
        n         = 9 + db;
        e.dut     = d;
        e.bits    = '0;
        for (int i = 0; i < 8; i++) e.bits[i] = CMD_BYTE[i];
        for (int j = 0; j < db; j++) e.bits[8+j] = data[db-1-j];
        e.bits[8+db] = 1'b0;
        e.nrise   = (cut > 0) ? cut : n;
        e.low     = cdiv(d) * (2 * n + 2);
        e.aborted = (cut > 0);
        e.gap     = -1;
        return e;
    endfunction

    task automatic push_exp(input exp_t e);
        exp_q.push_back(e);
        if (!e.aborted) exp_done[e.dut]++;
    endtask

    task automatic drive(input int d, input logic v, input logic [15:0] x);
        if (d == 0) begin
            in_valid = v;
            in_data  = x;
        end else begin
            in_valid2 = v;
            in_data2  = x[0];
        end
    endtask

    function automatic logic [5:0] outs(input int d);
        return (d == 0) ? {in_ready, sclk, mosi, cs_n, busy, done}
                        : {in_ready2, sclk2, mosi2, cs_n2, busy2, done2};
    endfunction

    function automatic logic ready(input int d);
        return (d == 0) ? in_ready : in_ready2;
    endfunction

    function automatic int accept_to_ready(input int d);
        return cdiv(d) * (2 * (9 + dbits(d)) + 3) + 1;
    endfunction

    // ---------------------------------------------------------------- monitor
    bit          mon_en = 1'b0;
    logic        prev_cs [2] = '{1'b1, 1'b1};
    logic        prev_sc [2] = '{1'b0, 1'b0};
    logic        prev_mo [2] = '{1'b0, 1'b0};
    int          rises    [2] = '{0, 0};
    int          low_cnt  [2] = '{0, 0};
    int          high_cnt [2] = '{0, 0};
    int          stab_err [2] = '{0, 0};
    logic [63:0] got      [2];

    task automatic mon_step(input int d, input logic cs, input logic sc,
                            input logic mo, input logic dn);
        exp_t        e;
        logic [63:0] mask;
        if (dn) done_cnt[d]++;
        if (!cs) begin
            if (prev_cs[d]) begin
                if (exp_q.size() > 0 && exp_q[0].gap >= 0)
                    check("gap_csn_high", high_cnt[d], exp_q[0].gap);
                rises[d]    = 0;
                low_cnt[d]  = 0;
                stab_err[d] = 0;
                got[d]      = '0;
            end
            low_cnt[d]++;
            if (sc && !prev_sc[d]) begin
                if (rises[d] < 64) got[d][rises[d]] = mo;
                rises[d]++;
            end else if (sc && prev_sc[d] && mo !== prev_mo[d]) begin
                stab_err[d]++;
            end
        end else begin
            if (!prev_cs[d]) begin
                check("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e    = exp_q.pop_front();
                    mask = (64'd1 << e.nrise) - 64'd1;
                    check("frame_dut", d, e.dut);
                    check("sclk_rises", rises[d], e.nrise);
                    check("mosi_at_rises", got[d] & mask, e.bits & mask);
                    if (!e.aborted) check("csn_low_cycles", low_cnt[d], e.low);
                    check("done_at_end", dn, !e.aborted);
                    check("mosi_stable_high", stab_err[d], 0);
                    check("sclk_low_csn_high", sc, 0);
                end
                high_cnt[d] = 0;
            end
            high_cnt[d]++;
        end
        prev_cs[d] = cs;
        prev_sc[d] = sc;
        prev_mo[d] = mo;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, cs_n, sclk, mosi, done);
            mon_step(1, cs_n2, sclk2, mosi2, done2);
        end
    end

    // --------------------------------------------------------------- stimulus
    // One transfer; in_data switches to data_after the cycle after acceptance.
    task automatic single(input int d, input logic [15:0] data, input logic [15:0] data_after);
        int k;
        @(negedge clk);
        drive(d, 1'b1, data);
        push_exp(make_exp(d, data, 0));
        @(posedge clk);
        @(negedge clk);
        drive(d, 1'b0, data_after);
        check("first_cycle_outs", outs(d), {1'b0, 1'b0, CMD_BYTE[0], 1'b0, 1'b1, 1'b0});
        k = 1;
        while (!ready(d) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("accept_to_ready", k, accept_to_ready(d));
    endtask

    // Two transfers with in_valid held high throughout.
    task automatic b2b(input int d, input logic [15:0] a, input logic [15:0] b);
        int   k;
        exp_t e;
        @(negedge clk);
        drive(d, 1'b1, a);
        push_exp(make_exp(d, a, 0));
        @(posedge clk);
        @(negedge clk);
        drive(d, 1'b1, b);
        e     = make_exp(d, b, 0);
        e.gap = cdiv(d) + 1;
        push_exp(e);
        k = 1;
        while (!ready(d) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("b2b_ready_first", k, accept_to_ready(d));
        @(posedge clk);
        @(negedge clk);
        drive(d, 1'b0, 16'h0000);
        k = 1;
        while (!ready(d) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("b2b_ready_second", k, accept_to_ready(d));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   r;
        int   cyc;
        logic ps;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs_dut0", outs(0), 6'b000100);
        check("reset_outs_dut1", outs(1), 6'b000100);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset_dut0", in_ready, 1);
        check("ready_after_reset_dut1", in_ready2, 1);
        mon_en = 1'b1;

        single(0, 16'hA5C3, 16'hA5C3);
        b2b(0, 16'h0001, 16'hFFFF);
        single(0, 16'hFFFF, 16'h0000);
        single(0, 16'h8001, 16'h7FFE);

        // Abort on the 12th sclk rise.
        @(negedge clk);
        drive(0, 1'b1, 16'hA5C3);
        push_exp(make_exp(0, 16'hA5C3, 12));
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000);
        r   = 0;
        cyc = 0;
        ps  = sclk;
        while (r < 12 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (sclk && !ps) r++;
            ps = sclk;
        end
        check("abort_rise_reached", r, 12);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_outs", outs(0), 6'b000100);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_abort", in_ready, 1);
        single(0, 16'hA5C3, 16'h0000);

        single(1, 16'h0001, 16'h0000);
        b2b(1, 16'h0001, 16'h0000);

        repeat (4) @(negedge clk);
        check("done_pulses_dut0", done_cnt[0], exp_done[0]);
        check("done_pulses_dut1", done_cnt[1], exp_done[1]);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
